// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a ROWS x COLS key matrix plus EXTRA direct key pins,
// debounces every key over DEBOUNCE frames and queues press codes in a FIFO
// drained by a valid/ready handshake.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int EXTRA    = 6,
    parameter int CODE_W   = 5,
    parameter int DEBOUNCE = 3,
    parameter int SETTLE   = 3,
    parameter int DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   o_word_lines,
    input  logic [COLS-1:0]   i_bit_lines,
    input  logic [EXTRA-1:0]  i_direct,
    output logic [CODE_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overflow
);
    localparam int NMAT   = ROWS * COLS;
    localparam int NKEYS  = NMAT + EXTRA;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {SCAN, DIRECT, EMIT} state_t;

    state_t              state;
    logic                run;
    logic [ROW_W-1:0]    row;
    logic [CNT_W-1:0]    settle_cnt;
    logic [COLS-1:0]     bit_s1, bit_s2;
    logic [EXTRA-1:0]    dir_s1, dir_s2;
    logic [NMAT-1:0]     raw;
    logic [NKEYS-1:0]    deb, pending;
    logic [DEBOUNCE-1:0] hist [NKEYS];

    logic [NKEYS-1:0]    frame_raw, rise, fall, pending_rest;
    logic [DEBOUNCE-1:0] next_hist [NKEYS];
    logic [CODE_W-1:0]   emit_code;
    logic                found;

    logic [CODE_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, head_next;
    logic [FILL_W-1:0]   count, count_next, count_after_pop;
    logic                push, pop, accept;

    // Per-key history update and debounced edge detection for this frame
    always_comb begin
        frame_raw = {dir_s2, raw};
        rise      = '0;
        fall      = '0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            next_hist[i] = (hist[i] << 1) | DEBOUNCE'(frame_raw[i]);
            rise[i]      = !deb[i] && (next_hist[i] == '1);
            fall[i]      = deb[i] && (next_hist[i] == '0);
        end
    end

    // Lowest pending key selects the code emitted this cycle
    always_comb begin
        emit_code    = '0;
        found        = 1'b0;
        pending_rest = pending & (pending - NKEYS'(1));
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (pending[i] && !found) begin
                found     = 1'b1;
                emit_code = CODE_W'(i);
            end
        end
    end

    // FIFO handshake: a full FIFO still accepts a push when a pop frees a slot
    always_comb begin
        push            = (state == EMIT) && (pending != '0);
        pop             = o_valid && i_ready;
        accept          = push && ((count != FILL_W'(DEPTH)) || pop);
        count_after_pop = count - FILL_W'(pop);
        count_next      = count_after_pop + FILL_W'(accept);
        head_next       = rd_ptr + PTR_W'(pop);
    end

    assign o_overflow = push && !accept;

    // Scan sequencer, synchronisers and debounce state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SCAN;
            run          <= 1'b0;
            row          <= '0;
            settle_cnt   <= '0;
            o_word_lines <= '0;
            bit_s1       <= '0;
            bit_s2       <= '0;
            dir_s1       <= '0;
            dir_s2       <= '0;
            raw          <= '0;
            deb          <= '0;
            pending      <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) hist[i] <= '0;
        end else begin
            bit_s1 <= i_bit_lines;
            bit_s2 <= bit_s1;
            dir_s1 <= i_direct;
            dir_s2 <= dir_s1;
            // The first cycle out of reset only loads the row-0 drive so that
            // each row, including the first, is driven for SETTLE+1 cycles.
            if (!run) begin
                run          <= 1'b1;
                o_word_lines <= ROWS'(1);
            end else begin
                case (state)
                    SCAN: begin
                        if (settle_cnt == CNT_W'(SETTLE)) begin
                            settle_cnt                <= '0;
                            raw[row*COLS +: COLS]     <= bit_s2;
                            if (row == ROW_W'(ROWS - 1)) begin
                                state        <= DIRECT;
                                o_word_lines <= '0;
                            end else begin
                                row          <= row + 1'b1;
                                o_word_lines <= o_word_lines << 1;
                            end
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    DIRECT: begin
                        for (int unsigned i = 0; i < NKEYS; i++) hist[i] <= next_hist[i];
                        deb     <= (deb | rise) & ~fall;
                        pending <= pending | rise;
                        state   <= EMIT;
                    end
                    EMIT: begin
                        pending <= pending_rest;
                        if (pending_rest == '0) begin
                            state        <= SCAN;
                            row          <= '0;
                            o_word_lines <= ROWS'(1);
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    // FIFO storage (no reset needed, guarded by count)
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= emit_code;
    end

    // FIFO pointers, fill level and registered head outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= head_next;
            count   <= count_next;
            o_valid <= (count_next != '0);
            // A push into an otherwise-empty FIFO becomes the new head directly
            if (accept && (count_after_pop == '0)) o_data <= emit_code;
            else                                   o_data <= mem[head_next];
        end
    end
endmodule
